hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core. Consumes the per-stage control bits produced by the controller (regwrite/memtoreg/memwrite in E/M/W) and register indices from the datapath.
- Produces forwarding selects, stall enables and FlushE, which feeds the controller's D->E clearing register.
- Also owns the data-memory request handshake: a multi-cycle memory freezes the pipeline until it is ready.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
TIMEOUT, 255, consecutive WAIT cycles before mem_err sets
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
rsD, rtD  in  5 each  source registers, decode stage
rsE, rtE  in  5 each  source registers, execute stage
writeregE, writeregM, writeregW  in  5 each  destination register per stage
regwriteE, regwriteM, regwriteW  in  1 each  register write enables
memtoregE, memtoregM  in  1 each  load in E / M
memwriteM  in  2  store size in M (00 = no store)
branchD, bneD  in  1 each  beq / bne in D
dmem_ready  in  1  data memory completes the access this cycle
dmem_req  out  1  data memory access request
forwardAD, forwardBD  out  1 each  D-stage branch comparator forward from M
forwardAE, forwardBE  out  2 each  E-stage ALU forward select
stallF, stallD, stallE, stallM  out  1 each  hold the stage register
flushE  out  1  clear the D->E register (controller FlushE)
flushW  out  1  clear the M->W register (insert bubble)
mem_err  out  1  sticky timeout flag
cnt_lw, cnt_br, cnt_mem  out  CNT_W each  load-use, branch and memory stall cycle counts

Behaviour:
Forwarding (combinational):
- forwardAE = 10 if rsE!=0 & rsE==writeregM & regwriteM.
- Else forwardAE = 01 if rsE!=0 & rsE==writeregW & regwriteW.
- Else forwardAE = 00. M has priority over W.
- forwardBE is the same function on rtE.
- forwardAD = rsD!=0 & rsD==writeregM & regwriteM. forwardBD is the same on rtD.

Hazard terms:
- lwstall = memtoregE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
- brD = branchD | bneD.
- branchstall is brD and any of:
  - regwriteE & writeregE!=0 & writeregE matches rsD or rtD;
  - memtoregM & writeregM!=0 & writeregM matches rsD or rtD.
- memacc = memtoregM | (memwriteM!=00).

Memory FSM, states IDLE and WAIT, with timer wcnt:
- IDLE: dmem_req = memacc.
  - memacc & dmem_ready: single-cycle access, no stall, stay IDLE.
  - memacc & !dmem_ready: memstall=1, go to WAIT, wcnt=1.
- WAIT: dmem_req = 1 and is held stable.
  - dmem_ready: memstall=0 this cycle, go to IDLE; the instruction leaves M at the next edge and is not re-requested.
  - Else memstall=1 and wcnt increments.
  - When wcnt reaches TIMEOUT, mem_err sets and stays set until reset. The FSM keeps waiting.

Output priority:
- memstall=1: stallF=stallD=stallE=stallM=1, flushW=1, flushE=0. lwstall and branchstall are masked and their counters do not increment.
- Else, when lwstall or branchstall: stallF=stallD=1, flushE=1, stallE=stallM=0, flushW=0.
- Else all stall/flush outputs are 0.

Counters (registered, saturating at all-ones):
- cnt_mem increments each memstall cycle.
- cnt_lw increments on unmasked lwstall.
- cnt_br increments on unmasked branchstall & !lwstall, so each cycle is counted at most once.

Reset:
- Next edge: state=IDLE, wcnt=0, counters=0, mem_err=0.
- While reset is high, dmem_req, all stalls, flushE and flushW are forced to 0. Forwards stay combinational.
- Reset asserted in WAIT abandons the access: dmem_req drops in the same cycle, and the FSM is in IDLE after the edge.

Decomposition:
- Shared package cpu_pkg holds:
  - fwd_sel_t enum: FWD_RF=00, FWD_WB=01, FWD_MEM=10;
  - mem_state_t enum: IDLE, WAIT;
  - REG_ZERO constant (5'd0).
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc; output q), instanced three times.
- Forwarding and hazard detection stay inline.

Test Plan:
- E-stage forwarding: add $3 in M and add $3 in W, with rsE=3, regwriteM=regwriteW=1 -> forwardAE=10. Drop regwriteM -> 01. Set rsE=0 with writeregM=0 -> 00.
- Load-use: memtoregE=1, writeregE=5, rtD=5 -> stallF=stallD=flushE=1, stallE=0, cnt_lw +1 per cycle. Next cycle, with memtoregE cleared -> all stall/flush outputs 0.
- Branch: branchD=1, rsD=7, regwriteE=1, writeregE=7 -> branchstall, flushE=1, cnt_br=1. Then writeregM=7 with regwriteM=1 and memtoregM=0 -> no stall, forwardAD=1.
- Multi-cycle memory: memtoregM=1, dmem_ready low for 3 cycles then high:
  - dmem_req=1 for 4 cycles; all stalls and flushW=1 for 3 cycles; cnt_mem=3; IDLE after.
  - A coincident lwstall during the wait gives flushE=0 and cnt_lw unchanged.
- Timeout, with TIMEOUT=4 and dmem_ready held low: mem_err=1 after the 4th WAIT cycle and stays 1 after dmem_ready rises. Pulse reset -> mem_err=0 and all counters 0.
- Reset in WAIT: assert reset during the 2nd stall cycle -> dmem_req=0 in that cycle, state IDLE after the edge, no stall after reset deasserts with memacc=0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline-control types for the 5-stage MIPS core: forward selects,
// data-memory handshake states and the forwarding-priority helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // M has priority over W; $0 is never forwarded.
  function automatic fwd_sel_t fwd_sel(input logic [4:0] src,
                                       input logic [4:0] wreg_m, input logic rw_m,
                                       input logic [4:0] wreg_w, input logic rw_w);
    if (src != REG_ZERO && rw_m && src == wreg_m) return FWD_MEM;
    if (src != REG_ZERO && rw_w && src == wreg_w) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && cnt_q != '1) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard/stall controller: forwarding selects, load-use and branch
// stalls, multi-cycle data-memory handshake, stall counters and timeout flag.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic [1:0]       memwriteM,
  input  logic             branchD,
  input  logic             bneD,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushE,
  output logic             flushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] cnt_lw,
  output logic [CNT_W-1:0] cnt_br,
  output logic [CNT_W-1:0] cnt_mem
);

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  mem_state_t     state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           mem_err_q, mem_err_d;
  fwd_sel_t       fwd_ae, fwd_be;
  logic           lwstall, brD, branchstall, memacc, memstall, req_raw;

  assign fwd_ae    = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
  assign fwd_be    = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardAE = fwd_ae;
  assign forwardBE = fwd_be;
  assign forwardAD = (rsD != REG_ZERO) && regwriteM && (rsD == writeregM);
  assign forwardBD = (rtD != REG_ZERO) && regwriteM && (rtD == writeregM);

  assign lwstall = memtoregE && (writeregE != REG_ZERO) &&
                   ((writeregE == rsD) || (writeregE == rtD));
  assign brD     = branchD || bneD;
  assign branchstall = brD &&
    ((regwriteE && (writeregE != REG_ZERO) && ((writeregE == rsD) || (writeregE == rtD))) ||
     (memtoregM && (writeregM != REG_ZERO) && ((writeregM == rsD) || (writeregM == rtD))));
  assign memacc  = memtoregM || (memwriteM != 2'b00);

  // wcnt counts WAIT cycles including the current one; it saturates at TIMEOUT.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    memstall  = 1'b0;
    req_raw   = memacc;
    case (state_q)
      IDLE: begin
        if (memacc && !dmem_ready) begin
          memstall = 1'b1;
          state_d  = WAIT;
          wcnt_d   = WCW'(1);
        end
      end
      WAIT: begin
        req_raw = 1'b1;
        if (dmem_ready) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else begin
          memstall = 1'b1;
          if (wcnt_q == WCW'(TIMEOUT)) mem_err_d = 1'b1;
          else                         wcnt_d    = wcnt_q + WCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (!reset) begin
      if (memstall) begin
        {stallF, stallD, stallE, stallM, flushW} = '1;
      end else if (lwstall || branchstall) begin
        {stallF, stallD, flushE} = '1;
      end
    end
  end

  assign dmem_req = req_raw && !reset;
  assign mem_err  = mem_err_q;

  sat_counter #(.W(CNT_W)) u_cnt_lw (
    .clk(clk), .reset(reset), .inc(!memstall && lwstall), .q(cnt_lw)
  );
  sat_counter #(.W(CNT_W)) u_cnt_br (
    .clk(clk), .reset(reset), .inc(!memstall && branchstall && !lwstall), .q(cnt_br)
  );
  sat_counter #(.W(CNT_W)) u_cnt_mem (
    .clk(clk), .reset(reset), .inc(memstall), .q(cnt_mem)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, multi-cycle memory sequences
// and randomized cycles against a cycle-level reference model.
module tb_hazard_unit;

  localparam int TO   = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic [1:0]    memwriteM;
  logic          branchD, bneD, dmem_ready;
  logic          dmem_req, forwardAD, forwardBD;
  logic [1:0]    forwardAE, forwardBE;
  logic          stallF, stallD, stallE, stallM, flushE, flushW, mem_err;
  logic [CW-1:0] cnt_lw, cnt_br, cnt_mem;

  hazard_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .memwriteM(memwriteM),
    .branchD(branchD), .bneD(bneD), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushW(flushW), .mem_err(mem_err),
    .cnt_lw(cnt_lw), .cnt_br(cnt_br), .cnt_mem(cnt_mem)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: "in a multi-cycle access" flag, number of completed
  // consecutive waiting cycles, sticky error and plain integer counters.
  bit m_busy;
  int m_waited;
  bit m_err;
  int m_lw, m_br, m_mem;

  // Snapshot of DUT outputs taken mid-cycle by apply().
  logic       s_req, s_flushE, s_flushW;
  logic [3:0] s_stall;

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic       rwE, rwM, rwW, mtE, mtM, brD, bneD, rdy;
    logic [1:0] eAE, eBE;
    logic       eAD, eBD, eStall, eReq;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src == 0) return 2'd0;
    if (regwriteM && src == writeregM) return 2'd2;
    if (regwriteW && src == writeregW) return 2'd1;
    return 2'd0;
  endfunction

  task automatic clear_inputs();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
    memwriteM = 2'b00;
    branchD = 1'b0; bneD = 1'b0;
    dmem_ready = 1'b1;
    reset = 1'b0;
  endtask

  // One clock cycle with the currently driven inputs: check combinational
  // outputs mid-cycle, advance the model at the edge, then check registers.
  task automatic apply(input string tag);
    logic [1:0] eAE, eBE;
    logic       eAD, eBD, lw, br, acc, ms, req, efE;
    logic [3:0] est;
    @(negedge clk);
    eAE = ref_fwd(rsE);
    eBE = ref_fwd(rtE);
    eAD = rsD != 0 && regwriteM && rsD == writeregM;
    eBD = rtD != 0 && regwriteM && rtD == writeregM;
    lw  = memtoregE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
    br  = (branchD || bneD) &&
          ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
           (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
    acc = memtoregM || memwriteM != 0;
    ms  = !reset && !dmem_ready && (m_busy || acc);
    req = !reset && (m_busy || acc);
    est = reset ? 4'b0000 : ms ? 4'b1111 : (lw || br) ? 4'b1100 : 4'b0000;
    efE = !reset && !ms && (lw || br);
    s_req = dmem_req; s_flushE = flushE; s_flushW = flushW;
    s_stall = {stallF, stallD, stallE, stallM};
    check({tag, " fwd"}, {forwardAE, forwardBE, forwardAD, forwardBD}, {eAE, eBE, eAD, eBD});
    check({tag, " ctl"}, {s_req, s_stall, s_flushE, s_flushW}, {req, est, efE, ms});
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_waited = 0; m_err = 0; m_lw = 0; m_br = 0; m_mem = 0;
    end else begin
      if (ms)      begin if (m_mem < CMAX) m_mem++; end
      else if (lw) begin if (m_lw < CMAX) m_lw++; end
      else if (br) begin if (m_br < CMAX) m_br++; end
      if (m_busy) begin
        if (dmem_ready) begin
          m_busy = 0; m_waited = 0;
        end else begin
          m_waited++;
          if (m_waited >= TO) m_err = 1;
        end
      end else if (acc && !dmem_ready) begin
        m_busy = 1; m_waited = 0;
      end
    end
    #1;
    check({tag, " regs"}, {cnt_lw, cnt_br, cnt_mem, mem_err},
          {CW'(m_lw), CW'(m_br), CW'(m_mem), m_err});
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    apply("rst");
    reset = 1'b0;
  endtask

  initial begin
    // Field order: rsD rtD rsE rtE wE wM wW | rwE rwM rwW mtE mtM brD bneD rdy | eAE eBE eAD eBD eStall eReq
    tbl[0]  = '{0,0,3,0,0,3,3, 0,1,1,0,0,0,0,1, 2'd2,2'd0,0,0,0,0};
    tbl[1]  = '{0,0,3,0,0,3,3, 0,0,1,0,0,0,0,1, 2'd1,2'd0,0,0,0,0};
    tbl[2]  = '{0,0,0,0,0,0,0, 0,1,1,0,0,0,0,1, 2'd0,2'd0,0,0,0,0};
    tbl[3]  = '{0,0,4,9,0,4,9, 0,1,1,0,0,0,0,1, 2'd2,2'd1,0,0,0,0};
    tbl[4]  = '{0,5,0,0,5,0,0, 1,0,0,1,0,0,0,1, 2'd0,2'd0,0,0,1,0};
    tbl[5]  = '{0,0,0,0,0,0,0, 1,0,0,1,0,0,0,1, 2'd0,2'd0,0,0,0,0};
    tbl[6]  = '{7,0,0,0,7,0,0, 1,0,0,0,0,1,0,1, 2'd0,2'd0,0,0,1,0};
    tbl[7]  = '{7,0,0,0,0,7,0, 0,1,0,0,0,1,0,1, 2'd0,2'd0,1,0,0,0};
    tbl[8]  = '{0,8,0,0,8,0,0, 1,0,0,0,0,0,1,1, 2'd0,2'd0,0,0,1,0};
    tbl[9]  = '{7,0,0,0,7,0,0, 1,0,0,0,0,0,0,1, 2'd0,2'd0,0,0,0,0};
    tbl[10] = '{0,6,0,0,0,6,0, 0,1,0,0,0,0,0,1, 2'd0,2'd0,0,1,0,0};
    tbl[11] = '{7,0,0,0,0,7,0, 0,0,0,0,1,1,0,1, 2'd0,2'd0,0,0,1,1};
    tbl[12] = '{5,0,0,0,5,0,0, 1,0,0,1,0,1,0,1, 2'd0,2'd0,0,0,1,0};

    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    apply("reset");
    check("reset regs", {cnt_lw, cnt_br, cnt_mem, mem_err}, 32'd0);
    check("reset outs", {s_req, s_stall, s_flushE, s_flushW}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      clear_inputs();
      rsD = tbl[i].rsD; rtD = tbl[i].rtD; rsE = tbl[i].rsE; rtE = tbl[i].rtE;
      writeregE = tbl[i].wE; writeregM = tbl[i].wM; writeregW = tbl[i].wW;
      regwriteE = tbl[i].rwE; regwriteM = tbl[i].rwM; regwriteW = tbl[i].rwW;
      memtoregE = tbl[i].mtE; memtoregM = tbl[i].mtM;
      branchD = tbl[i].brD; bneD = tbl[i].bneD; dmem_ready = tbl[i].rdy;
      apply($sformatf("vec%0d", i));
      check($sformatf("vec%0d fwdE", i), {forwardAE, forwardBE}, {tbl[i].eAE, tbl[i].eBE});
      check($sformatf("vec%0d fwdD", i), {forwardAD, forwardBD}, {tbl[i].eAD, tbl[i].eBD});
      check($sformatf("vec%0d stall", i), {s_req, s_stall, s_flushE, s_flushW},
            {tbl[i].eReq, tbl[i].eStall ? 6'b110010 : 6'b000000});
      if (i == 6) check("cnt_br after branch", cnt_br, 1);
      if (i == 4) check("cnt_lw after load-use", cnt_lw, 1);
    end

    // Multi-cycle load: three waiting cycles, a load-use hazard masked inside.
    clear_inputs();
    reset_pulse();
    memtoregM = 1'b1; dmem_ready = 1'b0;
    apply("memA1");
    check("memA1 outs", {s_req, s_stall, s_flushE, s_flushW}, 7'b1111101);
    memtoregE = 1'b1; writeregE = 5'd5; rtD = 5'd5;
    apply("memA2");
    check("memA2 outs", {s_req, s_stall, s_flushE, s_flushW}, 7'b1111101);
    apply("memA3");
    check("memA3 outs", {s_req, s_stall, s_flushE, s_flushW}, 7'b1111101);
    memtoregE = 1'b0; dmem_ready = 1'b1;
    apply("memA4");
    check("memA4 outs", {s_req, s_stall, s_flushE, s_flushW}, 7'b1000000);
    check("memA cnt_mem", cnt_mem, 3);
    check("memA cnt_lw masked", cnt_lw, 0);
    memtoregM = 1'b0;
    apply("memA5");
    check("memA5 no re-request", s_req, 0);

    // Timeout with dmem_ready held low.
    clear_inputs();
    reset_pulse();
    memtoregM = 1'b1; dmem_ready = 1'b0;
    repeat (4) apply("to");
    check("timeout not yet", mem_err, 0);
    apply("to5");
    check("timeout set", mem_err, 1);
    dmem_ready = 1'b1;
    apply("to_done");
    memtoregM = 1'b0;
    apply("to_after");
    check("timeout sticky", mem_err, 1);
    reset_pulse();
    check("timeout cleared", {cnt_lw, cnt_br, cnt_mem, mem_err}, 32'd0);

    // Reset during the second stall cycle abandons the access.
    clear_inputs();
    memtoregM = 1'b1; dmem_ready = 1'b0;
    apply("rw1");
    reset = 1'b1;
    apply("rw2");
    check("rw reset outs", {s_req, s_stall, s_flushE, s_flushW}, 7'b0000000);
    reset = 1'b0; memtoregM = 1'b0;
    apply("rw3");
    check("rw idle outs", {s_req, s_stall, s_flushE, s_flushW}, 7'b0000000);

    // Randomized cycles with a small register space to provoke matches.
    for (int n = 0; n < 500; n++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
      memtoregE = 1'($urandom);
      memtoregM = ($urandom_range(0, 3) == 0);
      memwriteM = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      branchD = 1'($urandom); bneD = ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 63) == 0);
      apply("rnd");
    end

    // Counter saturation on a long memory wait.
    clear_inputs();
    reset_pulse();
    memtoregM = 1'b1; dmem_ready = 1'b0;
    repeat (CMAX + 5) apply("sat");
    check("cnt_mem saturated", cnt_mem, CMAX);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
